// File: rtl/block_stack_ctrl.sv
// Stacking-game controller: a block sweeps across the playfield, the player stops it,
// and the overlap with the block below becomes the new block. Tracker handshake included.
module block_stack_ctrl #(
    parameter int SCREEN_W   = 160,
    parameter int UNIT_SHIFT = 3,
    parameter int START_SIZE = 8,
    parameter int MAX_LEVEL  = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       tick,
    input  logic       stop_btn,
    input  logic [8:0] prev_block_start,
    input  logic [8:0] prev_block_end,
    input  logic [3:0] prev_block_size,
    input  logic       done_tracking,
    output logic [8:0] curr_block_start,
    output logic [8:0] curr_block_end,
    output logic [3:0] curr_block_size,
    output logic       intersect_true,
    output logic       done_finding,
    output logic       reset_done_tracking,
    output logic       stop_true,
    output logic [3:0] level,
    output logic       game_over,
    output logic       win
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MOVE  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_TRACK = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    localparam logic [8:0] UNIT = 9'(1 << UNIT_SHIFT);

    logic [2:0] r_state;
    logic [8:0] r_x, r_cs, r_ce;
    logic       r_dir;              // 0 = moving right, 1 = moving left
    logic [3:0] r_size, r_level;
    logic       r_int, r_df, r_rdt, r_stp, r_go, r_win, r_stop_q;

    logic [8:0] w_w, w_mv_end, w_os, w_oe, w_len;
    logic [3:0] w_nxt_lvl;
    logic       w_edge, w_fit_r, w_fit_l, w_ovl;

    assign w_w       = 9'(r_size) << UNIT_SHIFT;
    assign w_mv_end  = r_x + w_w - 9'd1;
    assign w_edge    = stop_btn & ~r_stop_q;
    // Widened to 10 bits so the lookahead sum cannot wrap
    assign w_fit_r   = ({1'b0, r_x} + {1'b0, w_w} + {1'b0, UNIT}) <= 10'(SCREEN_W);
    assign w_fit_l   = r_x >= UNIT;
    assign w_os      = (r_cs > prev_block_start) ? r_cs : prev_block_start;
    assign w_oe      = (r_ce < prev_block_end) ? r_ce : prev_block_end;
    assign w_ovl     = w_os <= w_oe;
    assign w_len     = w_oe - w_os + 9'd1;
    assign w_nxt_lvl = r_level + 4'd1;

    assign curr_block_start    = (r_state == S_MOVE) ? r_x : r_cs;
    assign curr_block_end      = (r_state == S_MOVE) ? w_mv_end : r_ce;
    assign curr_block_size     = r_size;
    assign intersect_true      = r_int;
    assign done_finding        = r_df;
    assign reset_done_tracking = r_rdt;
    assign stop_true           = r_stp;
    assign level               = r_level;
    assign game_over           = r_go;
    assign win                 = r_win;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_cs     <= '0;
            r_ce     <= '0;
            r_dir    <= 1'b0;
            r_size   <= '0;
            r_level  <= '0;
            r_int    <= 1'b0;
            r_df     <= 1'b0;
            r_rdt    <= 1'b0;
            r_stp    <= 1'b0;
            r_go     <= 1'b0;
            r_win    <= 1'b0;
            r_stop_q <= 1'b0;
        end else begin
            r_stop_q <= stop_btn;
            r_rdt    <= 1'b0;
            r_stp    <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_x     <= '0;
                        r_dir   <= 1'b0;
                        r_size  <= 4'(START_SIZE);
                        r_level <= '0;
                        r_go    <= 1'b0;
                        r_win   <= 1'b0;
                        r_int   <= 1'b0;
                        r_rdt   <= 1'b1;
                        r_state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    // A stop edge takes priority over a coincident tick
                    if (w_edge) begin
                        r_stp   <= 1'b1;
                        r_cs    <= r_x;
                        r_ce    <= w_mv_end;
                        r_state <= S_CALC;
                    end else if (tick) begin
                        if (!r_dir) begin
                            if (w_fit_r) r_x <= r_x + UNIT;
                            else begin
                                r_dir <= 1'b1;
                                if (w_fit_l) r_x <= r_x - UNIT;
                            end
                        end else begin
                            if (w_fit_l) r_x <= r_x - UNIT;
                            else begin
                                r_dir <= 1'b0;
                                if (w_fit_r) r_x <= r_x + UNIT;
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (prev_block_size == 4'd0) begin
                        r_int <= 1'b1;
                    end else begin
                        r_int <= w_ovl;
                        if (w_ovl) begin
                            r_cs   <= w_os;
                            r_ce   <= w_oe;
                            r_size <= 4'(w_len >> UNIT_SHIFT);
                        end
                    end
                    r_df    <= 1'b1;
                    r_state <= S_TRACK;
                end
                S_TRACK: begin
                    if (done_tracking) begin
                        r_df    <= 1'b0;
                        r_rdt   <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (!r_int) begin
                        r_go    <= 1'b1;
                        r_state <= S_OVER;
                    end else begin
                        r_level <= w_nxt_lvl;
                        if (w_nxt_lvl == 4'(MAX_LEVEL)) begin
                            r_win   <= 1'b1;
                            r_go    <= 1'b1;
                            r_state <= S_OVER;
                        end else begin
                            r_x     <= '0;
                            r_dir   <= 1'b0;
                            r_state <= S_MOVE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/block_stack_ctrl.md
BLOCK_STACK_CTRL -- requirements
Module: block_stack_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning playfield width in pixels.
REQ-002 SHALL have parameter UNIT_SHIFT, default 3, meaning log2 of pixels per size unit (UNIT = 8).
REQ-003 SHALL have parameter START_SIZE, default 8, meaning block size in units at game start.
REQ-004 SHALL have parameter MAX_LEVEL, default 15, meaning level count that ends the game in a win.
REQ-005 SHALL have one clock, clk (input, 1), and an asynchronous active-high reset, resetn (input, 1).
REQ-006 SHALL have port start, input, 1, meaning begin a new game.
REQ-007 SHALL have port tick, input, 1, meaning a one-cycle movement strobe.
REQ-008 SHALL have port stop_btn, input, 1, meaning the player stop button (level signal).
REQ-009 SHALL have ports prev_block_start and prev_block_end, input, 9 each, meaning the tracked block below.
REQ-010 SHALL have port prev_block_size, input, 4, meaning the tracked size; 0 means no block below.
REQ-011 SHALL have port done_tracking, input, 1, meaning the tracker has captured the block.
REQ-012 SHALL have ports curr_block_start and curr_block_end, output, 9 each, meaning the moving or trimmed block span.
REQ-013 SHALL have port curr_block_size, output, 4, meaning the current size in units.
REQ-014 SHALL have ports intersect_true, done_finding, reset_done_tracking and stop_true, output, 1 each, meaning the tracker handshake.
REQ-015 SHALL have ports level (output, 4), game_over (output, 1) and win (output, 1), meaning game status.

Function
REQ-016 SHALL implement states IDLE, MOVE, CALC, TRACK, CLEAR and OVER.
REQ-017 In IDLE or OVER, start SHALL load x=0, dir=right, size=START_SIZE, level=0, clear game_over/win, pulse reset_done_tracking one cycle, go to MOVE.
REQ-018 SHALL drive curr_block_start=x and curr_block_end=x+(size<<UNIT_SHIFT)-1 in MOVE.
REQ-019 On tick moving right: if x+w+UNIT<=SCREEN_W then x+=UNIT, else dir=left and x-=UNIT (hold if x<UNIT); moving left mirrors this at 0.
REQ-020 SHALL detect the stop_btn rising edge with a registered prior value, and pulse stop_true for one cycle on the edge while in MOVE.
REQ-021 When the stop edge and tick fall in the same cycle, stop SHALL win and x SHALL NOT move; go to CALC.
REQ-022 In CALC (one cycle), with prev_block_size==0: intersect_true=1 and span/size are unchanged.
REQ-023 In CALC otherwise: os=max(starts) and oe=min(ends); intersect_true=(os<=oe); if true, curr span=os..oe and size=(oe-os+1)>>UNIT_SHIFT.
REQ-024 In TRACK, done_finding SHALL be held high with the curr outputs stable until done_tracking==1.
REQ-025 The next cycle (CLEAR) SHALL drop done_finding and pulse reset_done_tracking for one cycle.
REQ-026 After CLEAR, if intersect_true==0: game_over=1 and go to OVER.
REQ-027 After CLEAR, otherwise level+=1; if the new level==MAX_LEVEL then win=1, game_over=1 and go to OVER, else x=0, dir=right and go to MOVE.
REQ-028 done_finding and reset_done_tracking SHALL never be high in the same cycle.
REQ-029 start outside IDLE/OVER and stop outside MOVE SHALL be ignored.
REQ-030 All position arithmetic SHALL be 9-bit unsigned, with no value exceeding SCREEN_W-1.

Reset
REQ-031 resetn high SHALL asynchronously force IDLE, all outputs 0, x=0, dir=right and the stop edge register to 0.
REQ-032 Reset mid-operation SHALL abandon any handshake, with no pending pulse after release.

Verification
REQ-033 Reset, start, 13 ticks -> x goes 0,8..96 then reverses to 88; curr 88..151, size 8.
REQ-034 First level, stop at x=16, prev_size=0 -> CALC gives 16..79, size 8, intersect 1; done_finding holds until done_tracking; level 1.
REQ-035 prev 16..79 size 8, stop at x=40 -> curr 40..79, size 5, intersect 1, level increments.
REQ-036 prev 0..15 size 2, stop at x=96 (size 8) -> intersect 0, game_over=1, OVER; start restarts at level 0.
REQ-037 tick and stop edge in the same cycle -> x unchanged, stop_true pulses once; resetn mid-TRACK -> all outputs 0 immediately.
REQ-038 15 successful stops -> level=15, win=1, game_over=1.
